// File: rtl/mem_dump_tx.sv
// Streams WORD_COUNT 32-bit memory words out of an 8N1 UART, little-endian byte
// order, followed by one byte holding the XOR of every data byte sent.
//   IDLE      | waiting for START
//   READ      | MEM_RD strobe at the current word address
//   LATCH     | capture MEM_DIN into the word buffer
//   START_BIT | start bit of a data byte
//   DATA_BITS | eight data bits, LSB first
//   STOP_BIT  | stop bit; advances the byte, the word or the phase
//   CHECKSUM  | complete 10-bit frame carrying the checksum byte
//   FINISH    | one-cycle DONE pulse
module mem_dump_tx #(
  parameter int CLK_RATE = 50,
  parameter int BAUD     = 115200,
  parameter int DIV      = (CLK_RATE * 1000000 + BAUD / 2) / BAUD
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [31:0] START_ADDR,
  input  logic [15:0] WORD_COUNT,
  output logic [31:0] MEM_ADDR,
  output logic        MEM_RD,
  input  logic [31:0] MEM_DIN,
  output logic        TX,
  output logic        BUSY,
  output logic        DONE
);

  localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, START_BIT, DATA_BITS, STOP_BIT, CHECKSUM, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    cksum_q, cksum_d;
  logic [31:0]   buf_q, buf_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;

  logic       bit_end;
  logic [1:0] byte_idx_nx;
  logic [2:0] data_bit_nx;
  logic [7:0] cur_byte;
  logic [7:0] next_byte;
  logic [9:0] ck_frame;

  assign bit_end     = (baud_q == BAUD_LAST);
  assign byte_idx_nx = byte_idx_q + 2'd1;
  assign data_bit_nx = bit_cnt_q[2:0] + 3'd1;
  assign cur_byte    = buf_q[{byte_idx_q, 3'b000} +: 8];
  assign next_byte   = buf_q[{byte_idx_nx, 3'b000} +: 8];
  assign ck_frame    = {1'b1, cksum_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cksum_d    = cksum_q;
    buf_d      = buf_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    baud_d     = '0;
    tx_d       = tx_q;

    // TX is assigned alongside each transition so the flop leads the new state
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (START) begin
          addr_d     = START_ADDR & 32'hFFFF_FFFC;
          cnt_d      = WORD_COUNT;
          cksum_d    = 8'h00;
          byte_idx_d = 2'd0;
          bit_cnt_d  = 4'd0;
          if (WORD_COUNT == 16'd0) begin
            state_d = CHECKSUM;
            tx_d    = 1'b0;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        buf_d      = MEM_DIN;
        byte_idx_d = 2'd0;
        bit_cnt_d  = 4'd0;
        cksum_d    = cksum_q ^ MEM_DIN[7:0];
        tx_d       = 1'b0;
        state_d    = START_BIT;
      end
      START_BIT: begin
        baud_d = bit_end ? '0 : baud_q + BW'(1);
        if (bit_end) begin
          state_d   = DATA_BITS;
          bit_cnt_d = 4'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA_BITS: begin
        baud_d = bit_end ? '0 : baud_q + BW'(1);
        if (bit_end) begin
          if (bit_cnt_q == 4'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = cur_byte[data_bit_nx];
          end
        end
      end
      STOP_BIT: begin
        baud_d = bit_end ? '0 : baud_q + BW'(1);
        if (bit_end) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_nx;
            cksum_d    = cksum_q ^ next_byte;
            tx_d       = 1'b0;
            state_d    = START_BIT;
          end else begin
            addr_d = addr_q + 32'd4;
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q != 16'd1) begin
              state_d = READ;
            end else begin
              state_d   = CHECKSUM;
              bit_cnt_d = 4'd0;
              tx_d      = 1'b0;
            end
          end
        end
      end
      CHECKSUM: begin
        baud_d = bit_end ? '0 : baud_q + BW'(1);
        if (bit_end) begin
          if (bit_cnt_q == 4'd9) begin
            state_d = FINISH;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = ck_frame[bit_cnt_q + 4'd1];
          end
        end
      end
      FINISH: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      cksum_q    <= '0;
      buf_q      <= '0;
      byte_idx_q <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cksum_q    <= cksum_d;
      buf_q      <= buf_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
    end
  end

  assign MEM_ADDR = addr_q;
  assign MEM_RD   = (state_q == READ);
  assign TX       = tx_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == FINISH);

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: a fast instance (DIV=4) for functional cases and a
// default-parameter instance (DIV=434) for exact bit timing.
module tb_mem_dump_tx;
  localparam int DIV_F = 4;
  localparam int DIV_S = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f, start_f, mem_rd_f, tx_f, busy_f, done_f;
  logic [31:0] addr_f, mem_addr_f, mem_din_f;
  logic [15:0] wc_f;
  logic        rst_s, start_s, mem_rd_s, tx_s, busy_s, done_s;
  logic [31:0] addr_s, mem_addr_s, mem_din_s;
  logic [15:0] wc_s;

  mem_dump_tx #(.DIV(DIV_F)) u_dut_f (
    .CLK(clk), .RESET_N(rst_f), .START(start_f), .START_ADDR(addr_f),
    .WORD_COUNT(wc_f), .MEM_ADDR(mem_addr_f), .MEM_RD(mem_rd_f),
    .MEM_DIN(mem_din_f), .TX(tx_f), .BUSY(busy_f), .DONE(done_f)
  );

  mem_dump_tx u_dut_s (
    .CLK(clk), .RESET_N(rst_s), .START(start_s), .START_ADDR(addr_s),
    .WORD_COUNT(wc_s), .MEM_ADDR(mem_addr_s), .MEM_RD(mem_rd_s),
    .MEM_DIN(mem_din_s), .TX(tx_s), .BUSY(busy_s), .DONE(done_s)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem_seed = 32'h0;
  logic [7:0]  rx_f[$], rx_s[$];
  logic [31:0] rd_f[$], rd_s[$];
  int          done_cnt_f = 0, done_cnt_s = 0, rd_long_f = 0, rd_long_s = 0;
  logic        rd_prev_f = 1'b0, rd_prev_s = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  function automatic logic tx_of(input int inst);   return (inst == 0) ? tx_f   : tx_s;   endfunction
  function automatic logic busy_of(input int inst); return (inst == 0) ? busy_f : busy_s; endfunction
  function automatic logic rst_of(input int inst);  return (inst == 0) ? rst_f  : rst_s;  endfunction

  task automatic set_in(input int inst, input logic s, input logic [31:0] a, input logic [15:0] w);
    if (inst == 0) begin start_f = s; addr_f = a; wc_f = w; end
    else           begin start_s = s; addr_s = a; wc_s = w; end
  endtask

  // memory returns data by the edge after the READ cycle; also logs reads/DONE
  always @(negedge clk) begin
    if (mem_rd_f) begin rd_f.push_back(mem_addr_f); mem_din_f <= mem_val(mem_addr_f); end
    if (mem_rd_s) begin rd_s.push_back(mem_addr_s); mem_din_s <= mem_val(mem_addr_s); end
    if (mem_rd_f && rd_prev_f) rd_long_f <= rd_long_f + 1;
    if (mem_rd_s && rd_prev_s) rd_long_s <= rd_long_s + 1;
    rd_prev_f <= mem_rd_f;
    rd_prev_s <= mem_rd_s;
    if (done_f) done_cnt_f <= done_cnt_f + 1;
    if (done_s) done_cnt_s <= done_cnt_s + 1;
  end

  task automatic uart_mon(input int inst, input int div);
    logic [9:0] frame;
    logic       bad, aborted;
    forever begin
      @(negedge clk);
      if (rst_of(inst) && tx_of(inst) === 1'b0) begin
        frame = '0; bad = 1'b0; aborted = 1'b0;
        for (int s = 1; s < 10 * div; s++) begin
          @(negedge clk);
          if (!rst_of(inst)) begin aborted = 1'b1; break; end
          if (s % div == 0) frame[s / div] = tx_of(inst);
          else if (tx_of(inst) !== frame[s / div]) bad = 1'b1;
        end
        if (!aborted) begin
          chk("bit_width", 32'(bad), 32'd0);
          chk("stop_bit", 32'(frame[9]), 32'd1);
          if (inst == 0) rx_f.push_back(frame[8:1]);
          else           rx_s.push_back(frame[8:1]);
        end
      end
    end
  endtask

  initial uart_mon(0, DIV_F);
  initial uart_mon(1, DIV_S);

  task automatic do_dump(input int inst, input logic [31:0] a, input int wc, input int extra_at);
    logic [7:0]  exp_b[$], got_b[$];
    logic [31:0] exp_rd[$], got_rd[$];
    logic [31:0] base, w;
    logic [7:0]  ck;
    int div, exp_cyc, busy_n, guard, done0, rdl0;
    div  = (inst == 0) ? DIV_F : DIV_S;
    base = a & 32'hFFFF_FFFC;
    ck   = 8'h00;
    for (int i = 0; i < wc; i++) begin
      w = mem_val(base + 32'(4 * i));
      exp_rd.push_back(base + 32'(4 * i));
      for (int k = 0; k < 4; k++) begin
        exp_b.push_back(w[8*k +: 8]);
        ck ^= w[8*k +: 8];
      end
    end
    exp_b.push_back(ck);
    exp_cyc = (4 * wc + 1) * 10 * div + 2 * wc + 1;

    if (inst == 0) begin rx_f.delete(); rd_f.delete(); done0 = done_cnt_f; rdl0 = rd_long_f; end
    else           begin rx_s.delete(); rd_s.delete(); done0 = done_cnt_s; rdl0 = rd_long_s; end

    set_in(inst, 1'b1, a, 16'(wc));
    @(negedge clk);
    set_in(inst, 1'b0, a, 16'(wc));
    chk("busy_rise", 32'(busy_of(inst)), 32'd1);
    busy_n = 0; guard = 0;
    while (busy_of(inst) && guard < exp_cyc + 100) begin
      busy_n++;
      if (extra_at != 0 && busy_n == extra_at)
        set_in(inst, 1'b1, $urandom, 16'($urandom_range(1, 5)));
      else
        set_in(inst, 1'b0, a, 16'(wc));
      @(negedge clk);
      guard++;
    end
    set_in(inst, 1'b0, a, 16'(wc));
    if (guard >= exp_cyc + 100) chk("timeout", 32'd1, 32'd0);
    chk("busy_cycles", 32'(busy_n), 32'(exp_cyc));
    repeat (3) @(negedge clk);
    chk("busy_after", 32'(busy_of(inst)), 32'd0);

    if (inst == 0) begin
      got_b = rx_f; got_rd = rd_f;
      chk("done_pulses", 32'(done_cnt_f - done0), 32'd1);
      chk("rd_pulse_len", 32'(rd_long_f - rdl0), 32'd0);
    end else begin
      got_b = rx_s; got_rd = rd_s;
      chk("done_pulses", 32'(done_cnt_s - done0), 32'd1);
      chk("rd_pulse_len", 32'(rd_long_s - rdl0), 32'd0);
    end
    chk("byte_count", 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("byte[%0d]", i), 32'(got_b[i]), 32'(exp_b[i]));
    chk("read_count", 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
      chk($sformatf("read_addr[%0d]", i), got_rd[i], exp_rd[i]);
  endtask

  initial begin
    int done0;
    rst_f = 1'b0; rst_s = 1'b0;
    set_in(0, 1'b0, 32'h0, 16'h0);
    set_in(1, 1'b0, 32'h0, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_f), 32'd1);
    chk("rst_busy", 32'(busy_f), 32'd0);
    chk("rst_done", 32'(done_f), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd_f), 32'd0);
    chk("rst_mem_addr", mem_addr_f, 32'h0);
    rst_f = 1'b1; rst_s = 1'b1;
    @(negedge clk);

    do_dump(0, 32'h0000_0100, 1, 0);
    if (rx_f.size() > 0) chk("ck_0x100", 32'(rx_f[rx_f.size()-1]), 32'h08);
    do_dump(0, $urandom, 0, 0);
    do_dump(0, 32'hFFFF_FFFE, 2, 0);
    mem_seed = $urandom;
    do_dump(0, $urandom, 3, 3 + 20 * DIV_F + 2);

    // reset during the 5th data bit of the second byte
    set_in(0, 1'b1, $urandom, 16'd2);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0, 16'd0);
    repeat (2 + 15 * DIV_F + 1) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_f), 32'd1);
    done0 = done_cnt_f;
    #1 rst_f = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_f), 32'd1);
    chk("abort_busy", 32'(busy_f), 32'd0);
    chk("abort_done", 32'(done_f), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt_f - done0), 32'd0);
    chk("abort_mem_rd", 32'(mem_rd_f), 32'd0);
    rst_f = 1'b1;
    do_dump(0, $urandom, 2, 0);

    for (int r = 0; r < 6; r++) begin
      mem_seed = $urandom;
      do_dump(0, $urandom, $urandom_range(0, 4), 0);
    end

    mem_seed = $urandom;
    do_dump(1, $urandom, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 Parameter CLK_RATE, default 50, system clock frequency in MHz.
REQ-002 Parameter BAUD, default 115200, serial bit rate in bits per second.
REQ-003 Parameter DIV, default round(CLK_RATE*1e6/BAUD) = 434, clocks per serial bit.
REQ-004 Port CLK  in  1  system clock; all state updates on its rising edge.
REQ-005 Port RESET_N  in  1  asynchronous, active-low reset.
REQ-006 Port START  in  1  one-cycle dump request; sampled only in IDLE.
REQ-007 Port START_ADDR  in  32  byte address of the first word; bits [1:0] ignored (treated as 0).
REQ-008 Port WORD_COUNT  in  16  number of 32-bit words to send; 0 is legal.
REQ-009 Port MEM_ADDR  out  32  word-aligned read address to the data memory port.
REQ-010 Port MEM_RD  out  1  read strobe; memory returns MEM_DIN exactly one clock after MEM_RD=1.
REQ-011 Port MEM_DIN  in  32  read data from memory.
REQ-012 Port TX  out  1  UART serial output, 8N1, idle high.
REQ-013 Port BUSY  out  1  high from the cycle after START is accepted until the cycle DONE pulses, inclusive.
REQ-014 Port DONE  out  1  one-cycle pulse after the final stop bit.

Function
REQ-015 FSM states SHALL be IDLE, READ, LATCH, START_BIT, DATA_BITS, STOP_BIT, CHECKSUM and FINISH.
REQ-016 In IDLE, START=1 SHALL latch START_ADDR&~3 and WORD_COUNT, clear the checksum, and go to READ, or go to CHECKSUM when WORD_COUNT=0.
REQ-017 In READ, MEM_RD SHALL be 1 for exactly one cycle with MEM_ADDR = the current address; the next state is LATCH.
REQ-018 In LATCH, MEM_DIN SHALL be captured into a 32-bit word buffer, byte index set to 0, next state START_BIT.
REQ-019 Bytes SHALL be sent little-endian: buffer[7:0] first, then [15:8], [23:16], [31:24].
REQ-020 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit held on TX for exactly DIV clocks.
REQ-021 The baud counter SHALL count 0..DIV-1, restart at 0 on every bit boundary, and never free-run across IDLE.
REQ-022 The checksum SHALL be the 8-bit XOR of every data byte sent, updated when each byte enters START_BIT.
REQ-023 After the stop bit of byte 3, the address SHALL increment by 4 (wrapping modulo 2^32) and the remaining count by -1; if the remaining count is nonzero the next state is READ, otherwise CHECKSUM.
REQ-024 CHECKSUM SHALL transmit the checksum byte with identical framing, then go to FINISH.
REQ-025 FINISH SHALL assert DONE for one cycle and return to IDLE; MEM_RD SHALL never be asserted outside READ.
REQ-026 START while BUSY=1 SHALL be ignored with no effect on state, counters or outputs.
REQ-027 Consecutive bytes SHALL be back-to-back, with no idle bit between the stop bit and the next start bit, except for the 2 READ/LATCH cycles between words.
REQ-028 TX SHALL be registered (glitch-free) and equal 1 in IDLE, FINISH, READ and LATCH.
REQ-029 Total transmit time SHALL be (4*WORD_COUNT+1)*10*DIV clocks plus 2 cycles per word plus FINISH.

Reset
REQ-030 RESET_N=0 SHALL immediately force state IDLE, TX=1, MEM_RD=0, BUSY=0, DONE=0, and zero all counters, the address, the checksum and the buffer.
REQ-031 Reset asserted mid-byte SHALL abort the transfer with no completion of the frame and no DONE pulse.
REQ-032 After RESET_N rises, the block SHALL accept START on the first clock edge.

Verification
REQ-033 DIV=4, START_ADDR=0x100, WORD_COUNT=1, mem[0x100]=0x12345678 -> one MEM_RD at 0x100; bytes 78,56,34,12 then checksum 0x08; DONE once; BUSY low afterward.
REQ-034 WORD_COUNT=0, START=1 -> no MEM_RD; single byte 0x00 sent; DONE after 10*DIV+ clocks.
REQ-035 START_ADDR=0xFFFFFFFE, WORD_COUNT=2 -> reads at 0xFFFFFFFC then 0x00000000 (wrap); 9 bytes sent.
REQ-036 Second START pulse during byte 2 of a 3-word dump -> ignored; exactly 13 bytes and one DONE.
REQ-037 RESET_N low at the 5th data bit of byte 1 -> TX=1 within the same cycle, BUSY=0, no DONE; a new START then runs a clean dump.
REQ-038 Bench UART monitor at DIV=434 checks every bit width is exactly 434 clocks and every stop bit is 1.
